// File: rtl/sdram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single SDRAM controller slave port.
// Commands pass through combinationally while granted; a tag FIFO routes read data back.
module sdram_port_arbiter #(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned MAX_RD = 8
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writedata,
    output logic [DATA_W/8-1:0]   s_byteenable,
    input  logic                  s_waitrequest,
    input  logic [DATA_W-1:0]     s_readdata,
    input  logic                  s_readdatavalid,

    output logic                  rd_underflow
);

    localparam int unsigned PTR_W = (MAX_RD > 1) ? $clog2(MAX_RD) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t             state;
    logic               grant;
    logic               last_grant;
    logic [MAX_RD-1:0]  tag_mem;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   rd_count;

    logic rd_full;
    logic elig0;
    logic elig1;
    logic sel_read;
    logic sel_write;
    logic issuing;
    logic accept;
    logic push;
    logic pop;
    logic head;

    assign rd_full   = (rd_count == CNT_W'(MAX_RD));
    assign elig0     = (m0_read | m0_write) & ~(m0_read & rd_full);
    assign elig1     = (m1_read | m1_write) & ~(m1_read & rd_full);

    assign sel_read  = grant ? m1_read  : m0_read;
    assign sel_write = grant ? m1_write : m0_write;
    assign issuing   = (state == ISSUE);
    assign accept    = issuing & ~s_waitrequest;
    assign push      = accept & sel_read;
    assign pop       = s_readdatavalid & (rd_count != '0);
    assign head      = tag_mem[rd_ptr];

    // Granted requester drives the slave directly; read wins over a simultaneous write.
    assign s_read       = issuing & sel_read;
    assign s_write      = issuing & sel_write & ~sel_read;
    assign s_address    = grant ? m1_address    : m0_address;
    assign s_writedata  = grant ? m1_writedata  : m0_writedata;
    assign s_byteenable = grant ? m1_byteenable : m0_byteenable;

    assign m0_waitrequest   = ~(accept & ~grant);
    assign m1_waitrequest   = ~(accept &  grant);
    assign m0_readdatavalid = pop & ~head;
    assign m1_readdatavalid = pop &  head;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

    // Arbitration FSM, read tag FIFO and underflow flag.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state        <= IDLE;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rd_count     <= '0;
            rd_underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (elig0 && elig1) begin
                        grant <= ~last_grant;
                        state <= ISSUE;
                    end else if (elig0) begin
                        grant <= 1'b0;
                        state <= ISSUE;
                    end else if (elig1) begin
                        grant <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!s_waitrequest) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) begin
                tag_mem[wr_ptr] <= grant;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   rd_count <= rd_count + CNT_W'(1);
                2'b01:   rd_count <= rd_count - CNT_W'(1);
                default: rd_count <= rd_count;
            endcase

            if (s_readdatavalid && (rd_count == '0)) begin
                rd_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus a randomized run against a queue-based model.
module tb_sdram_port_arbiter;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BE_W   = 2;
    localparam int unsigned MAX_RD = 8;

    logic              clk_clk = 1'b0;
    logic              reset_reset;
    logic [ADDR_W-1:0] m0_address, m1_address, s_address;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
    logic [BE_W-1:0]   m0_byteenable, m1_byteenable, s_byteenable;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic              s_read, s_write, s_waitrequest, s_readdatavalid;
    logic              rd_underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk_clk = ~clk_clk;

    sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RD(MAX_RD)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .rd_underflow(rd_underflow)
    );

    task automatic nxt();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
    endtask

    task automatic do_reset();
        nxt();
        clear_inputs();
        reset_reset = 1'b1;
        nxt();
        nxt();
        reset_reset = 1'b0;
    endtask

    task automatic set_req(input int n, input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
        if (n == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
        end
    endtask

    function automatic logic wait_of(input int n);
        return (n == 0) ? m0_waitrequest : m1_waitrequest;
    endfunction

    // Hold one command until accepted (bounded), then drop it.
    task automatic issue(input int n, input bit rd, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit ok;
        ok = 1'b0;
        nxt();
        set_req(n, rd, !rd, a, d, 2'b11);
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk_clk);
            if (wait_of(n) == 1'b0) ok = 1'b1;
            else nxt();
        end
        nxt();
        set_req(n, 1'b0, 1'b0, '0, '0, '0);
        checks++;
        if (!ok) begin errors++; $display("FAIL issue_timeout requester %0d got no accept expected accept", n); end
    endtask

    task automatic test_reset();
        nxt();
        reset_reset = 1'b1;
        m0_read = 1'b1; m1_write = 1'b1; s_readdatavalid = 1'b1;
        @(negedge clk_clk);
        checks++;
        if ({s_read, s_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, rd_underflow} !== 7'b0011000) begin
            errors++;
            $display("FAIL reset_outputs got %b expected 0011000", {s_read, s_write, m0_waitrequest, m1_waitrequest,
                     m0_readdatavalid, m1_readdatavalid, rd_underflow});
        end
        nxt();
        clear_inputs();
        reset_reset = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        set_req(0, 1'b1, 1'b0, 24'h000123, '0, 2'b11);
        @(negedge clk_clk);
        checks++;
        if ({s_read, m0_waitrequest} !== 2'b01) begin
            errors++; $display("FAIL single_pre got %b expected 01", {s_read, m0_waitrequest});
        end
        nxt();
        @(negedge clk_clk);
        checks++;
        if ({s_read, s_write, m0_waitrequest, m1_waitrequest, s_address} !== {4'b1001, 24'h000123}) begin
            errors++;
            $display("FAIL single_issue got %b/%h expected 1001/000123", {s_read, s_write, m0_waitrequest, m1_waitrequest}, s_address);
        end
        nxt();
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk_clk);
        checks++;
        if (s_read !== 1'b0) begin errors++; $display("FAIL single_after got s_read=%b expected 0", s_read); end
        nxt();
        nxt();
        s_readdatavalid = 1'b1; s_readdata = 16'hBEEF;
        @(negedge clk_clk);
        checks++;
        if ({m0_readdatavalid, m1_readdatavalid, m0_readdata, rd_underflow} !== {2'b10, 16'hBEEF, 1'b0}) begin
            errors++;
            $display("FAIL single_rdv got %b %b %h %b expected 1 0 beef 0", m0_readdatavalid, m1_readdatavalid, m0_readdata, rd_underflow);
        end
        nxt();
        s_readdatavalid = 1'b0;
    endtask

    task automatic test_contention();
        logic [ADDR_W-1:0] a[2];
        logic [DATA_W-1:0] d[2];
        logic [BE_W-1:0]   be[2];
        bit took[2];
        int acc[$];
        do_reset();
        a[0] = 24'h10; a[1] = 24'h20; d[0] = 16'hA000; d[1] = 16'hB000; be[0] = 2'b01; be[1] = 2'b10;
        took[0] = 1'b0; took[1] = 1'b0;
        for (int i = 0; i < 9; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (took[n]) begin a[n] = a[n] + 24'd1; d[n] = d[n] + 16'd1; be[n] = ~be[n]; end
                set_req(n, 1'b0, 1'b1, a[n], d[n], be[n]);
                took[n] = 1'b0;
            end
            @(negedge clk_clk);
            for (int n = 0; n < 2; n++) begin
                if (wait_of(n) == 1'b0) begin
                    took[n] = 1'b1;
                    acc.push_back(n);
                    checks++;
                    if ({s_write, s_read, s_address, s_writedata, s_byteenable} !== {2'b10, a[n], d[n], be[n]}) begin
                        errors++;
                        $display("FAIL contention_cmd m%0d got %b%b %h %h %b expected 10 %h %h %b", n, s_write, s_read,
                                 s_address, s_writedata, s_byteenable, a[n], d[n], be[n]);
                    end
                end
            end
            nxt();
        end
        clear_inputs();
        checks++;
        if (acc.size() != 4 || acc[0] != 0 || acc[1] != 1 || acc[2] != 0 || acc[3] != 1) begin
            errors++; $display("FAIL contention_order got %p expected '{0,1,0,1}", acc);
        end
    endtask

    task automatic test_stall();
        do_reset();
        set_req(1, 1'b0, 1'b1, 24'h0000AA, 16'h1111, 2'b11);
        s_waitrequest = 1'b1;
        @(negedge clk_clk);
        for (int i = 0; i < 5; i++) begin
            nxt();
            if (i == 0) set_req(0, 1'b1, 1'b0, 24'h000055, '0, 2'b11);
            @(negedge clk_clk);
            checks++;
            if ({s_address, s_write, m1_waitrequest, m0_waitrequest} !== {24'h0000AA, 3'b111}) begin
                errors++;
                $display("FAIL stall_hold cyc %0d got %h %b%b%b expected 0000aa 111", i, s_address, s_write, m1_waitrequest, m0_waitrequest);
            end
        end
        nxt();
        s_waitrequest = 1'b0;
        @(negedge clk_clk);
        checks++;
        if ({s_address, m1_waitrequest, m0_waitrequest} !== {24'h0000AA, 2'b01}) begin
            errors++; $display("FAIL stall_accept got %h %b%b expected 0000aa 01", s_address, m1_waitrequest, m0_waitrequest);
        end
        nxt();
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk_clk);
        checks++;
        if ({s_read, s_write, m0_waitrequest} !== 3'b001) begin
            errors++; $display("FAIL stall_gap got %b expected 001", {s_read, s_write, m0_waitrequest});
        end
        nxt();
        @(negedge clk_clk);
        checks++;
        if ({s_read, m0_waitrequest, s_address} !== {2'b10, 24'h000055}) begin
            errors++; $display("FAIL stall_m0 got %b%b %h expected 10 000055", s_read, m0_waitrequest, s_address);
        end
        nxt();
        clear_inputs();
    endtask

    task automatic test_tags();
        int order[4];
        order[0] = 0; order[1] = 1; order[2] = 1; order[3] = 0;
        do_reset();
        for (int i = 0; i < 4; i++) issue(order[i], 1'b1, 24'(i), '0);
        for (int i = 0; i < 4; i++) begin
            nxt();
            s_readdatavalid = 1'b1; s_readdata = 16'(i + 1);
            @(negedge clk_clk);
            checks++;
            if ({m0_readdatavalid, m1_readdatavalid, m0_readdata, m1_readdata} !==
                {order[i] == 0, order[i] == 1, 16'(i + 1), 16'(i + 1)}) begin
                errors++;
                $display("FAIL tags_route %0d got %b%b %h expected m%0d %h", i, m0_readdatavalid, m1_readdatavalid,
                         m0_readdata, order[i], 16'(i + 1));
            end
        end
        nxt();
        s_readdatavalid = 1'b0;
    endtask

    task automatic test_full_fifo();
        do_reset();
        for (int i = 0; i < 8; i++) issue(0, 1'b1, 24'(16 + i), '0);
        nxt();
        set_req(0, 1'b1, 1'b0, 24'h000077, '0, 2'b11);
        set_req(1, 1'b0, 1'b1, 24'h000088, 16'h4242, 2'b11);
        @(negedge clk_clk);
        nxt();
        @(negedge clk_clk);
        checks++;
        if ({m0_waitrequest, m1_waitrequest, s_write, s_read, s_address} !== {4'b1010, 24'h000088}) begin
            errors++; $display("FAIL full_write got %b %h expected 1010 000088",
                               {m0_waitrequest, m1_waitrequest, s_write, s_read}, s_address);
        end
        nxt();
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_clk);
            checks++;
            if ({m0_waitrequest, s_read} !== 2'b10) begin
                errors++; $display("FAIL full_stall %0d got %b expected 10", i, {m0_waitrequest, s_read});
            end
            nxt();
        end
        s_readdatavalid = 1'b1; s_readdata = 16'h1234;
        @(negedge clk_clk);
        checks++;
        if ({m0_readdatavalid, m1_readdatavalid, m0_waitrequest} !== 3'b101) begin
            errors++; $display("FAIL full_pop got %b expected 101", {m0_readdatavalid, m1_readdatavalid, m0_waitrequest});
        end
        nxt();
        s_readdatavalid = 1'b0;
        @(negedge clk_clk);
        nxt();
        @(negedge clk_clk);
        checks++;
        if ({m0_waitrequest, s_read, s_address} !== {2'b01, 24'h000077}) begin
            errors++; $display("FAIL full_resume got %b %h expected 01 000077", {m0_waitrequest, s_read}, s_address);
        end
        nxt();
        clear_inputs();
    endtask

    task automatic test_underflow();
        do_reset();
        issue(0, 1'b1, 24'h1, '0);
        issue(1, 1'b1, 24'h2, '0);
        issue(0, 1'b1, 24'h3, '0);
        do_reset();
        @(negedge clk_clk);
        checks++;
        if (rd_underflow !== 1'b0) begin errors++; $display("FAIL uf_clear got %b expected 0", rd_underflow); end
        nxt();
        s_readdatavalid = 1'b1; s_readdata = 16'h5555;
        @(negedge clk_clk);
        checks++;
        if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
            errors++; $display("FAIL uf_route got %b expected 00", {m0_readdatavalid, m1_readdatavalid});
        end
        nxt();
        s_readdatavalid = 1'b0;
        repeat (3) nxt();
        @(negedge clk_clk);
        checks++;
        if (rd_underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b expected 1", rd_underflow); end
        do_reset();
        @(negedge clk_clk);
        checks++;
        if (rd_underflow !== 1'b0) begin errors++; $display("FAIL uf_reset got %b expected 0", rd_underflow); end
    endtask

    // Random traffic: model holds "which requester is mid-transfer" and a queue of read owners.
    task automatic test_random();
        bit act[2], rq[2], wq[2], el[2], ew[2], erdv[2];
        logic [ADDR_W-1:0] a[2];
        logic [DATA_W-1:0] d[2];
        logic [BE_W-1:0]   be[2];
        bit busy, g, last, uf, pop, sr, sw;
        int tagq[$];
        int sz, kind;
        busy = 1'b0; g = 1'b0; last = 1'b1; uf = 1'b0;
        act[0] = 1'b0; act[1] = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            nxt();
            for (int n = 0; n < 2; n++) begin
                if (!act[n] && $urandom_range(2) == 0) begin
                    act[n] = 1'b1;
                    kind = int'($urandom_range(2));
                    rq[n] = (kind != 1); wq[n] = (kind != 0);
                    a[n] = ADDR_W'($urandom); d[n] = DATA_W'($urandom); be[n] = BE_W'($urandom);
                end
                set_req(n, act[n] && rq[n], act[n] && wq[n], a[n], d[n], be[n]);
            end
            s_waitrequest   = ($urandom_range(2) == 0);
            s_readdatavalid = (tagq.size() > 0) ? ($urandom_range(2) == 0) : ($urandom_range(199) == 0);
            s_readdata      = DATA_W'($urandom);
            @(negedge clk_clk);

            sr = busy && rq[g];
            sw = busy && wq[g] && !rq[g];
            sz = tagq.size();
            pop = s_readdatavalid && (sz > 0);
            for (int n = 0; n < 2; n++) begin
                ew[n]   = !(busy && (int'(g) == n) && !s_waitrequest);
                erdv[n] = pop && (tagq[0] == n);
            end
            checks++;
            if ({s_read, s_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, rd_underflow} !==
                {sr, sw, ew[0], ew[1], erdv[0], erdv[1], uf}) begin
                errors++;
                $display("FAIL rand_ctrl cyc %0d got %b expected %b", cyc,
                         {s_read, s_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, rd_underflow},
                         {sr, sw, ew[0], ew[1], erdv[0], erdv[1], uf});
            end
            checks++;
            if ({m0_readdata, m1_readdata} !== {s_readdata, s_readdata}) begin
                errors++; $display("FAIL rand_rdata cyc %0d got %h %h expected %h", cyc, m0_readdata, m1_readdata, s_readdata);
            end
            if (busy) begin
                checks++;
                if ({s_address, s_writedata, s_byteenable} !== {a[g], d[g], be[g]}) begin
                    errors++;
                    $display("FAIL rand_payload cyc %0d got %h %h %b expected %h %h %b", cyc, s_address, s_writedata,
                             s_byteenable, a[g], d[g], be[g]);
                end
            end

            for (int n = 0; n < 2; n++) el[n] = act[n] && !(rq[n] && sz == MAX_RD);
            if (pop) void'(tagq.pop_front());
            if (s_readdatavalid && sz == 0) uf = 1'b1;
            if (busy) begin
                if (!s_waitrequest) begin
                    if (rq[g]) tagq.push_back(int'(g));
                    last = g; busy = 1'b0; act[g] = 1'b0;
                end
            end else if (el[0] || el[1]) begin
                busy = 1'b1;
                g = (el[0] && el[1]) ? !last : el[1];
            end
        end
        clear_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_stall();
        test_tags();
        test_full_fifo();
        test_underflow();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
